// File: rtl/rose_impl_checker.sv
// rose_impl_checker
//   Synthesizable checker for the implication "ante |=> $rose(sig)".
//   An antecedent sampled high at edge k is resolved at edge k+1. The attempt
//   passes if sig rose at that edge, meaning it was sampled 0 at edge k and 1
//   at edge k+1. Otherwise the attempt fails.
//
// Parameters
//   CNT_W          width of the pass/fail/cycle counters (legal 4..32)
//
// Ports
//   clk            sole clock, all state updates on posedge
//   rst            synchronous, active-high reset
//   ante           antecedent, sampled at posedge clk
//   sig            monitored signal, sampled at posedge clk
//   rose           registered rise detect of sig
//   pass           one-cycle pulse, matured attempt held
//   fail           one-cycle pulse, matured attempt violated (sticky when configured)
//   pass_cnt       saturating count of passes
//   fail_cnt       saturating count of failures
//   fail_seen      set on the first failure since reset
//   first_fail_cyc cycle counter value at the edge that resolved the first failure
//
// Configuration
//   ROSE_IMPL_CHECKER_STICKY_FAIL_EN
//     When defined, fail is held high from the first failure until reset.
//     From that point pass is suppressed and pass_cnt/fail_cnt are frozen.
//     rose and the cycle counter keep running.
module rose_impl_checker #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ante,
  input  logic             sig,
  output logic             rose,
  output logic             pass,
  output logic             fail,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             fail_seen,
  output logic [CNT_W-1:0] first_fail_cyc
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic             prev_sig;
  logic             pending;
  logic [CNT_W-1:0] cyc_cnt;

  logic rose_now;
  logic frozen;
  logic hit;
  logic miss;
  logic fail_next;

  always_comb begin
    rose_now = sig & ~prev_sig;
`ifdef ROSE_IMPL_CHECKER_STICKY_FAIL_EN
    // After the first failure, attempts still retire but record nothing.
    // The held fail level already reports the violation.
    frozen    = fail_seen;
    hit       = pending & rose_now & ~frozen;
    miss      = pending & ~rose_now & ~frozen;
    fail_next = fail | miss;
`else
    frozen    = 1'b0;
    hit       = pending & rose_now & ~frozen;
    miss      = pending & ~rose_now & ~frozen;
    fail_next = miss;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_sig       <= 1'b0;
      pending        <= 1'b0;
      rose           <= 1'b0;
      pass           <= 1'b0;
      fail           <= 1'b0;
      pass_cnt       <= '0;
      fail_cnt       <= '0;
      fail_seen      <= 1'b0;
      first_fail_cyc <= '0;
      cyc_cnt        <= '0;
    end else begin
      prev_sig <= sig;
      pending  <= ante;
      rose     <= rose_now;
      cyc_cnt  <= cyc_cnt + ONE;
      pass     <= hit;
      fail     <= fail_next;
      if (hit && (pass_cnt != '1)) begin
        pass_cnt <= pass_cnt + ONE;
      end
      if (miss && (fail_cnt != '1)) begin
        fail_cnt <= fail_cnt + ONE;
      end
      if (miss && !fail_seen) begin
        fail_seen      <= 1'b1;
        first_fail_cyc <= cyc_cnt;
      end
    end
  end

endmodule

// File: tb/tb_rose_impl_checker.sv
module tb_rose_impl_checker;

  localparam int unsigned W = 4;
`ifdef ROSE_IMPL_CHECKER_STICKY_FAIL_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         ante = 1'b0;
  logic         sig = 1'b0;
  logic         rose, pass, fail, fail_seen;
  logic [W-1:0] pass_cnt, fail_cnt, first_fail_cyc;

  rose_impl_checker #(.CNT_W(W)) dut (
    .clk(clk), .rst(rst), .ante(ante), .sig(sig),
    .rose(rose), .pass(pass), .fail(fail),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
    .fail_seen(fail_seen), .first_fail_cyc(first_fail_cyc)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           at;
    bit           p;
    bit           f;
    logic [W-1:0] pc;
    logic [W-1:0] fc;
    bit           seen;
    logic [W-1:0] ffc;
  } exp_t;

  exp_t sb[$];
  int   edges = 0;
  int   total = 0;
  int   passed = 0;
  bit   hold = 1'b0;

  // Reference state for the expected counters. Expected per-attempt outcomes
  // come from the hand-written vectors.
  logic [W-1:0] m_pc, m_fc, m_ffc, m_cyc;
  bit           m_seen;

  always @(posedge clk) edges++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h want %0h (edge %0d)", name, act, exp, edges);
  endtask

  task automatic push(input byte e);
    exp_t it;
    it.at = edges + 2;
    it.p  = (e == "P");
    it.f  = (e == "F");
    if (STICKY && m_seen) begin
      it.p = 1'b0;
      it.f = 1'b1;
    end else if (it.p) begin
      if (m_pc != '1) m_pc = m_pc + 1'b1;
    end else begin
      if (m_fc != '1) m_fc = m_fc + 1'b1;
    end
    if (it.f && !m_seen) begin
      m_seen = 1'b1;
      m_ffc  = m_cyc + 1'b1;
    end
    it.pc = m_pc; it.fc = m_fc; it.seen = m_seen; it.ffc = m_ffc;
    sb.push_back(it);
  endtask

  // One clock edge. e is the hand-computed outcome of the attempt started by
  // this edge's antecedent: P pass, F fail, N no attempt or attempt abandoned.
  task automatic step(input logic a, input logic s, input byte e);
    ante = a;
    sig  = s;
    if (a && e != "N") push(e);
    @(posedge clk);
    #2;
    m_cyc = m_cyc + 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ante = 1'b0;
    sig = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    hold = 1'b0;
    m_pc = '0; m_fc = '0; m_ffc = '0; m_cyc = '0; m_seen = 1'b0;
  endtask

  // Monitor: compares the scoreboard entry due at this edge. It also flags any
  // pass or fail output that no queued entry accounts for.
  always @(negedge clk) begin
    if (!rst) begin
      if (sb.size() > 0 && sb[0].at == edges) begin
        exp_t it;
        it = sb.pop_front();
        chk("pass", 32'(pass), 32'(it.p));
        chk("fail", 32'(fail), 32'(it.f));
        chk("pass_cnt", 32'(pass_cnt), 32'(it.pc));
        chk("fail_cnt", 32'(fail_cnt), 32'(it.fc));
        chk("fail_seen", 32'(fail_seen), 32'(it.seen));
        chk("first_fail_cyc", 32'(first_fail_cyc), 32'(it.ffc));
        if (STICKY && it.f) hold = 1'b1;
      end else begin
        if (pass || (fail && !hold)) chk("unexpected_pulse", 32'({pass, fail}), 32'(0));
        if (hold && !fail) chk("sticky_fail_held", 32'(fail), 32'(1));
      end
    end
  end

  initial begin
    m_pc = '0; m_fc = '0; m_ffc = '0; m_cyc = '0; m_seen = 1'b0;

    // Outputs after reset.
    do_reset();
    chk("rst_rose", 32'(rose), 32'(0));
    chk("rst_pass_fail", 32'({pass, fail}), 32'(0));
    chk("rst_counts", 32'({pass_cnt, fail_cnt, first_fail_cyc}), 32'(0));
    chk("rst_fail_seen", 32'(fail_seen), 32'(0));

    // Single attempt: ante at the third edge with sig 0, sig rises at the next edge.
    step(0, 0, "N"); step(0, 0, "N"); step(1, 0, "P"); step(0, 1, "N"); step(0, 0, "N");
    chk("single_pass_cnt", 32'(pass_cnt), 32'(1));

    // sig toggles each edge and ante sits on the low samples, so every attempt passes.
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) step(1, 0, "P");
      else            step(0, 1, "N");
    end
    step(0, 0, "N");
    chk("toggle_pass_cnt", 32'(pass_cnt), 32'(4));
    chk("toggle_fail_cnt", 32'(fail_cnt), 32'(0));
    chk("toggle_fail_seen", 32'(fail_seen), 32'(0));

    // sig toggles each edge and ante sits on the high samples, so every attempt fails.
    // The first attempt starts at cycle 1 and resolves at cycle 2.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 1) step(1, 1, "F");
      else            step(0, 0, "N");
    end
    step(0, 0, "N");
    chk("toggle_first_fail_cyc", 32'(first_fail_cyc), 32'(2));

    // Antecedent held on two edges: the first attempt passes and the second fails.
    step(1, 0, "P"); step(1, 1, "F"); step(0, 1, "N"); step(0, 0, "N");

    // An attempt pending when reset asserts is dropped.
    // Afterwards sig=1 at the first edge out of reset shows up as rose.
    step(1, 0, "N");
    do_reset();
    chk("abandon_all_zero", 32'({rose, pass, fail, fail_seen, pass_cnt, fail_cnt}), 32'(0));
    step(0, 1, "N");
    chk("post_rst_rose", 32'(rose), 32'(1));
    step(0, 0, "N");

    // 20 passing attempts saturate the 4-bit pass counter at 15.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step(1, 0, "P");
      step(0, 1, "N");
    end
    step(0, 0, "N");
    chk("sat_pass_cnt", 32'(pass_cnt), 32'(15));

`ifdef ROSE_IMPL_CHECKER_STICKY_FAIL_EN
    // One failure followed by passes: fail stays high and both counters freeze.
    do_reset();
    step(1, 0, "F"); step(0, 0, "N");
    step(1, 0, "P"); step(0, 1, "N");
    step(1, 0, "P"); step(0, 1, "N");
    step(0, 0, "N"); step(0, 0, "N");
    chk("sticky_fail", 32'(fail), 32'(1));
    chk("sticky_fail_cnt", 32'(fail_cnt), 32'(1));
    chk("sticky_pass_cnt", 32'(pass_cnt), 32'(0));
    do_reset();
    chk("sticky_cleared", 32'(fail), 32'(0));
`endif

    step(0, 0, "N");
    step(0, 0, "N");
    chk("scoreboard_drained", 32'(sb.size()), 32'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
